// File: rtl/util_edge_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-mode encodings, width helper.
// Latency: n/a (constants and functions only).
// Backpressure: n/a.
package util_edge_pkg;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/util_edge_ch.sv
// One conditioner channel: synchroniser, stable-count debounce, edge strobes, pulse stretch, optional sticky flag.
// Latency: din step to level_o/rise_o/fall_o in SYNC_STAGES+STABLE_CYCLES cycles; pulse_o one cycle later.
// Backpressure: none; free-running, every accepted edge is reported.
module util_edge_ch
    import util_edge_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int PULSE_WIDTH   = 1,
    parameter bit RST_LEVEL     = 1'b0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       din,
    input  logic [1:0] edge_mode,
    output logic       level_o,
    output logic       rise_o,
    output logic       fall_o,
    output logic       pulse_o
`ifdef UTIL_EDGE_STICKY_EN
    ,
    input  logic       evt_clr,
    output logic       evt_flag
`endif
);

    localparam int CNT_W  = clog2(STABLE_CYCLES + 1);
    localparam int PCNT_W = clog2(PULSE_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PULSE_WIDTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   q;
    logic [PCNT_W-1:0]      pcnt;

    // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {SYNC_STAGES{RST_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_q <= RST_LEVEL;
            cnt     <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (s == level_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_q <= s;
                cnt     <= '0;
                rise_q  <= s;
                fall_q  <= ~s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        q = 1'b0;
        case (edge_mode)
            EDGE_NONE: q = 1'b0;
            EDGE_RISE: q = rise_q;
            EDGE_FALL: q = fall_q;
            EDGE_BOTH: q = rise_q | fall_q;
        endcase
    end

    // A new qualifying edge reloads rather than adds, so back-to-back edges never lengthen past PULSE_WIDTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
        end else if (q) begin
            pcnt <= PCNT_LOAD;
        end else if (pcnt != '0) begin
            pcnt <= pcnt - PCNT_W'(1);
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign pulse_o = (pcnt != '0);

`ifdef UTIL_EDGE_STICKY_EN
    logic flag_q;

    // Set has priority so an event landing in the clear cycle is not lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flag_q <= 1'b0;
        end else if (q) begin
            flag_q <= 1'b1;
        end else if (evt_clr) begin
            flag_q <= 1'b0;
        end
    end

    assign evt_flag = flag_q;
`endif

endmodule

// File: rtl/util_edge_detect_mc.sv
// NUM_CH independent input conditioners (sync, debounce, edge detect, pulse stretch); sticky flags with UTIL_EDGE_STICKY_EN.
// Latency: SYNC_STAGES+STABLE_CYCLES cycles to level/strobes, +1 to pulse_o.
// Backpressure: none; purely per-channel, no shared state.
module util_edge_detect_mc
    import util_edge_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int PULSE_WIDTH   = 1,
    parameter bit RST_LEVEL     = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_CH-1:0]   din,
    input  logic [2*NUM_CH-1:0] edge_mode,
    output logic [NUM_CH-1:0]   level_o,
    output logic [NUM_CH-1:0]   rise_o,
    output logic [NUM_CH-1:0]   fall_o,
    output logic [NUM_CH-1:0]   pulse_o
`ifdef UTIL_EDGE_STICKY_EN
    ,
    input  logic [NUM_CH-1:0]   evt_clr,
    output logic [NUM_CH-1:0]   evt_flag
`endif
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        util_edge_ch #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .PULSE_WIDTH   (PULSE_WIDTH),
            .RST_LEVEL     (RST_LEVEL)
        ) u_ch (
            .clk       (clk),
            .rstn      (rstn),
            .din       (din[c]),
            .edge_mode (edge_mode[2*c +: 2]),
            .level_o   (level_o[c]),
            .rise_o    (rise_o[c]),
            .fall_o    (fall_o[c]),
            .pulse_o   (pulse_o[c])
`ifdef UTIL_EDGE_STICKY_EN
            ,
            .evt_clr   (evt_clr[c]),
            .evt_flag  (evt_flag[c])
`endif
        );
    end

endmodule

// File: tb/tb_util_edge_detect_mc.sv
// Bench for util_edge_detect_mc: directed scenarios plus randomized inputs against a sample-history reference model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/100ps
module tb_util_edge_detect_mc;

    localparam int NUM_CH        = 4;
    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int PULSE_WIDTH   = 6;
    localparam bit RST_LEVEL     = 1'b0;
    localparam int MW            = 2 * NUM_CH;
    localparam int HL            = SYNC_STAGES + STABLE_CYCLES;

    logic              clk       = 1'b0;
    logic              rstn      = 1'b0;
    logic [NUM_CH-1:0] din       = '1;
    logic [MW-1:0]     edge_mode = '0;
    logic [NUM_CH-1:0] level_o, rise_o, fall_o, pulse_o;
`ifdef UTIL_EDGE_STICKY_EN
    logic [NUM_CH-1:0] evt_clr   = '0;
    logic [NUM_CH-1:0] evt_flag;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    util_edge_detect_mc #(
        .NUM_CH        (NUM_CH),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .PULSE_WIDTH   (PULSE_WIDTH),
        .RST_LEVEL     (RST_LEVEL)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din       (din),
        .edge_mode (edge_mode),
        .level_o   (level_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .pulse_o   (pulse_o)
`ifdef UTIL_EDGE_STICKY_EN
        ,
        .evt_clr   (evt_clr),
        .evt_flag  (evt_flag)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: level flips once the last STABLE_CYCLES synchronised samples all disagree with it;
    // synchronised sample = din as seen SYNC_STAGES edges earlier; pulse high while within PULSE_WIDTH edges of a qualifying edge.
    bit     hist    [NUM_CH][HL];
    bit     m_level [NUM_CH];
    bit     m_rise  [NUM_CH];
    bit     m_fall  [NUM_CH];
    bit     m_flag  [NUM_CH];
    longint m_lastq [NUM_CH];
    longint cyc;

    task automatic model_reset();
        cyc = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < HL; i++) hist[c][i] = RST_LEVEL;
            m_level[c] = RST_LEVEL;
            m_rise[c]  = 1'b0;
            m_fall[c]  = 1'b0;
            m_flag[c]  = 1'b0;
            m_lastq[c] = -100;
        end
    endtask

    task automatic model_step();
        bit q;
        bit flip;
        cyc++;
        for (int c = 0; c < NUM_CH; c++) begin
            q = (edge_mode[2*c] && m_rise[c]) || (edge_mode[2*c+1] && m_fall[c]);
            if (q) m_lastq[c] = cyc;
`ifdef UTIL_EDGE_STICKY_EN
            if (q) m_flag[c] = 1'b1;
            else if (evt_clr[c]) m_flag[c] = 1'b0;
`endif
            for (int i = HL - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = din[c];
            flip = 1'b1;
            for (int i = SYNC_STAGES; i < HL; i++) begin
                if (hist[c][i] == m_level[c]) flip = 1'b0;
            end
            m_rise[c] = flip && !m_level[c];
            m_fall[c] = flip && m_level[c];
            if (flip) m_level[c] = !m_level[c];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare against the model.
    initial begin
        logic [NUM_CH-1:0] el, er, ef, ep, eg;
        forever begin
            @(negedge clk);
            if (rstn) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    el[c] = m_level[c];
                    er[c] = m_rise[c];
                    ef[c] = m_fall[c];
                    ep[c] = (cyc - m_lastq[c]) < PULSE_WIDTH;
                    eg[c] = m_flag[c];
                end
                chk("level_o", level_o, el);
                chk("rise_o",  rise_o,  er);
                chk("fall_o",  fall_o,  ef);
                chk("pulse_o", pulse_o, ep);
`ifdef UTIL_EDGE_STICKY_EN
                chk("evt_flag", evt_flag, eg);
`else
                if (eg != '0) chk("model_flag_idle", eg, 0);
`endif
            end
        end
    end

    // Event counters sampled 2ns after each active edge.
    int rise_cnt  [NUM_CH] = '{default: 0};
    int fall_cnt  [NUM_CH] = '{default: 0};
    int pulse_cnt [NUM_CH] = '{default: 0};
    logic [NUM_CH-1:0] pulse_prev = '0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int c = 0; c < NUM_CH; c++) begin
                rise_cnt[c] += int'(rise_o[c]);
                fall_cnt[c] += int'(fall_o[c]);
                if (pulse_o[c] && !pulse_prev[c]) pulse_cnt[c]++;
            end
            pulse_prev = pulse_o;
        end
    end

    task automatic wait_strobe(input int ch, input bit want_rise, input int lim, output int n);
        n = 0;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if (want_rise ? rise_o[ch] : fall_o[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n, hi, runs, total;
        bit lv, prev;
        int r0 [NUM_CH];
        int f0 [NUM_CH];
        int p0 [NUM_CH];
        int exp_p [NUM_CH] = '{0, 4, 4, 8};

        // Reset held with all inputs high: everything must read zero.
        repeat (3) @(negedge clk);
        chk("rst_level", level_o, 0);
        chk("rst_rise",  rise_o,  0);
        chk("rst_fall",  fall_o,  0);
        chk("rst_pulse", pulse_o, 0);
`ifdef UTIL_EDGE_STICKY_EN
        chk("rst_flag", evt_flag, 0);
`endif
        #2 rstn = 1'b1;
        wait_strobe(0, 1'b1, 20, n);
        chk("rst_rise_latency", n, SYNC_STAGES + 4);
        chk("rst_rise_all", rise_o, 4'hF);
        chk("rst_level_after", level_o, 4'hF);

        // Short glitch rejected; five-cycle pulse accepted.
        din = '0;
        repeat (12) @(negedge clk);
        r0 = rise_cnt;
        din[0] = 1'b1;
        repeat (3) @(negedge clk);
        din[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_rise", rise_cnt[0] - r0[0], 0);
        chk("glitch_level", level_o[0], 0);
        r0 = rise_cnt;
        n = 0;
        lv = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            din[0] = (i <= 5);
            @(negedge clk);
            if (rise_o[0] && n == 0) begin
                n  = i;
                lv = level_o[0];
            end
        end
        chk("hold5_latency", n, 6);
        chk("hold5_level", lv, 1);
        chk("hold5_rises", rise_cnt[0] - r0[0], 1);

        // Edge modes 00/01/10/11 on a period-20 square wave.
        edge_mode = 8'b11_10_01_00;
        repeat (4) @(negedge clk);
        r0 = rise_cnt;
        f0 = fall_cnt;
        p0 = pulse_cnt;
        for (int p = 0; p < 4; p++) begin
            din = '1;
            repeat (10) @(negedge clk);
            din = '0;
            repeat (10) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("mode_rise[%0d]", c),  rise_cnt[c] - r0[c], 4);
            chk($sformatf("mode_fall[%0d]", c),  fall_cnt[c] - f0[c], 4);
            chk($sformatf("mode_pulse[%0d]", c), pulse_cnt[c] - p0[c], exp_p[c]);
        end

        // Edges every 5 cycles with a 6-cycle stretch: one unbroken pulse.
        edge_mode[1:0] = 2'b11;
        repeat (4) @(negedge clk);
        hi = 0;
        runs = 0;
        prev = 1'b0;
        for (int i = 0; i < 60; i++) begin
            din[0] = (i < 30) && ((i / 5) % 2 == 0);
            @(negedge clk);
            if (pulse_o[0]) hi++;
            if (pulse_o[0] && !prev) runs++;
            prev = pulse_o[0];
        end
        chk("stretch_high_cycles", hi, 5 * 5 + PULSE_WIDTH);
        chk("stretch_runs", runs, 1);

`ifdef UTIL_EDGE_STICKY_EN
        edge_mode[5:4] = 2'b11;
        evt_clr = '1;
        @(negedge clk);
        evt_clr = '0;
        repeat (2) @(negedge clk);
        chk("sticky_idle", evt_flag[2], 0);
        din[2] = 1'b1;
        wait_strobe(2, 1'b1, 20, n);
        chk("sticky_rise_latency", n, 6);
        @(negedge clk);
        chk("sticky_set", evt_flag[2], 1);
        chk("sticky_pulse_same_cycle", pulse_o[2], 1);
        evt_clr[2] = 1'b1;
        @(negedge clk);
        evt_clr[2] = 1'b0;
        chk("sticky_clr", evt_flag[2], 0);
        din[2] = 1'b0;
        wait_strobe(2, 1'b0, 20, n);
        chk("sticky_fall_seen", n != 0, 1);
        evt_clr[2] = 1'b1;
        @(negedge clk);
        evt_clr[2] = 1'b0;
        chk("sticky_set_wins", evt_flag[2], 1);
`endif

        // Async reset while pulses are active; inputs return to the reset level.
        edge_mode = '1;
        repeat (10) @(negedge clk);
        din = '1;
        wait_strobe(0, 1'b1, 20, n);
        chk("pre_rst_rise_latency", n, 6);
        @(negedge clk);
        chk("pre_rst_pulse", pulse_o, 4'hF);
        din = '0;
        #2 rstn = 1'b0;
        #0.5;
        chk("async_rst_pulse", pulse_o, 0);
        chk("async_rst_level", level_o, 0);
        chk("async_rst_rise",  rise_o,  0);
        #0.5 rstn = 1'b1;
        r0 = rise_cnt;
        f0 = fall_cnt;
        p0 = pulse_cnt;
        repeat (15) @(negedge clk);
        total = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            total += (rise_cnt[c] - r0[c]) + (fall_cnt[c] - f0[c]) + (pulse_cnt[c] - p0[c]);
        end
        chk("post_rst_spurious", total, 0);

        // Randomized traffic: mixed glitch/stable runs, mode changes, clears, occasional mid-cycle resets.
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 4) == 0) din[c] = ~din[c];
            end
            if ($urandom_range(0, 39) == 0) edge_mode = MW'($urandom);
`ifdef UTIL_EDGE_STICKY_EN
            evt_clr = NUM_CH'($urandom) & NUM_CH'($urandom);
`endif
            if (i % 700 == 350) begin
                #2 rstn = 1'b0;
                #1 rstn = 1'b1;
            end
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
